// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: processes STEP bits per cycle through a
// ripple chain of full adders, with the carry registered between chunks.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, acc;
  logic             carry;
  logic [STEP-1:0]  chunk_sum;
  logic [STEP:0]    c;
  logic [WIDTH-1:0] acc_next;

  // Ripple chain over the current low chunk of the shifting operands
  always_comb begin
    c         = '0;
    chunk_sum = '0;
    c[0]      = carry;
    for (int unsigned i = 0; i < STEP; i++) begin
      chunk_sum[i] = a_r[i] ^ b_r[i] ^ c[i];
      c[i+1]       = (a_r[i] & b_r[i]) | (c[i] & (a_r[i] ^ b_r[i]));
    end
    // New chunk enters at the top; after N chunks the LSB chunk sits at bit 0
    acc_next = WIDTH'({chunk_sum, acc} >> STEP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub | cin;
            acc   <= '0;
          end
        end
        RUN: begin
          a_r   <= a_r >> STEP;
          b_r   <= b_r >> STEP;
          carry <= c[STEP];
          acc   <= acc_next;
          if (cnt == LAST) begin
            cnt  <= '0;
            sum  <= acc_next;
            cout <= c[STEP];
            ovf  <= c[STEP] ^ c[STEP-1];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench: two configurations (8/1 and 16/4) checked against an
// arithmetic reference model, with directed, backpressure, reset and random ops.
module tb_serial_adder_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
  logic [7:0] a8, b8, s8;
  logic        iv16, ir16, cin16, sub16, ov16, or16, co16, of16;
  logic [15:0] a16, b16, s16;

  serial_adder_n #(.WIDTH(8), .STEP(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .ovf(of8)
  );

  serial_adder_n #(.WIDTH(16), .STEP(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .ovf(of16)
  );

  int checks = 0;
  int errors = 0;

  logic        sel16;
  logic        cur_ir, cur_ov, cur_co, cur_of;
  logic [63:0] cur_s;
  assign cur_ir = sel16 ? ir16 : ir8;
  assign cur_ov = sel16 ? ov16 : ov8;
  assign cur_co = sel16 ? co16 : co8;
  assign cur_of = sel16 ? of16 : of8;
  assign cur_s  = sel16 ? 64'(s16) : 64'(s8);

  // Returns {ovf, cout, sum[63:0]} for a w-bit operation
  function automatic logic [65:0] ref_model(input int w, input logic [63:0] ta, tb_,
                                            input logic tc, ts);
    logic [64:0] mask, aa, bb, full;
    logic [63:0] s;
    logic co, ov;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, ta} & mask;
    bb   = ts ? (~{1'b0, tb_} & mask) : ({1'b0, tb_} & mask);
    full = aa + bb + 65'(ts ? 1'b1 : tc);
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, co, s};
  endfunction

  task automatic drive_in(input logic v, input logic [63:0] ta, tb_, input logic tc, ts);
    if (sel16) begin
      iv16 = v; a16 = ta[15:0]; b16 = tb_[15:0]; cin16 = tc; sub16 = ts;
    end else begin
      iv8 = v; a8 = ta[7:0]; b8 = tb_[7:0]; cin8 = tc; sub8 = ts;
    end
  endtask

  task automatic set_ready(input logic r);
    if (sel16) or16 = r;
    else       or8  = r;
  endtask

  task automatic run_op(input logic w16, input logic [63:0] ta, tb_,
                        input logic tc, ts, input int hold, input string name);
    logic [65:0] want;
    int n, w, nexp;
    sel16 = w16;
    w     = w16 ? 16 : 8;
    nexp  = w16 ? 4 : 8;
    want  = ref_model(w, ta, tb_, tc, ts);
    n = 0;
    while (!cur_ir && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) begin
      errors++;
      $display("FAIL %s in_ready timeout got=%0b expected=1", name, cur_ir);
    end
    drive_in(1'b1, ta, tb_, tc, ts);
    @(posedge clk); #1;
    drive_in(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    n = 0;
    while (!cur_ov && n < 50) begin
      @(posedge clk); #1; n++;
      if (cur_ir && !cur_ov) begin
        errors++;
        $display("FAIL %s in_ready_busy got=1 expected=0", name);
      end
    end
    checks++;
    if (n !== nexp) begin
      errors++;
      $display("FAIL %s latency got=%0d expected=%0d", name, n, nexp);
    end
    checks++;
    if ({cur_of, cur_co, cur_s} !== want) begin
      errors++;
      $display("FAIL %s result got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
               name, cur_s, cur_co, cur_of, want[63:0], want[64], want[65]);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({cur_ov, cur_ir, cur_of, cur_co, cur_s} !== {1'b1, 1'b0, want}) begin
        errors++;
        $display("FAIL %s hold%0d got ov=%b ir=%b sum=%h cout=%b ovf=%b expected ov=1 ir=0 sum=%h",
                 name, i, cur_ov, cur_ir, cur_s, cur_co, cur_of, want[63:0]);
      end
    end
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    checks++;
    if ({cur_ir, cur_ov, cur_of, cur_co, cur_s} !== {1'b1, 1'b0, want}) begin
      errors++;
      $display("FAIL %s release got ir=%b ov=%b sum=%h cout=%b ovf=%b expected ir=1 ov=0 sum=%h",
               name, cur_ir, cur_ov, cur_s, cur_co, cur_of, want[63:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ir8, ov8, s8, co8, of8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset8 got ir=%b ov=%b sum=%h cout=%b ovf=%b expected 1 0 00 0 0",
               ir8, ov8, s8, co8, of8);
    end
    checks++;
    if ({ir16, ov16, s16, co16, of16} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset16 got ir=%b ov=%b sum=%h cout=%b ovf=%b expected 1 0 0000 0 0",
               ir16, ov16, s16, co16, of16);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(1'b0, 64'h0F, 64'h01, 1'b0, 1'b0, 0, "add_0f_01");
    run_op(1'b0, 64'h7F, 64'h01, 1'b0, 1'b0, 0, "add_ovf");
    run_op(1'b0, 64'hFF, 64'h00, 1'b1, 1'b0, 0, "add_cin_wrap");
    run_op(1'b0, 64'h05, 64'h07, 1'b1, 1'b1, 0, "sub_borrow");
    run_op(1'b0, 64'h80, 64'h01, 1'b0, 1'b1, 0, "sub_ovf");
    run_op(1'b1, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 0, "add16_wrap");
    run_op(1'b1, 64'h7FF0, 64'h0123, 1'b1, 1'b0, 0, "add16_ovf");
  endtask

  task automatic test_backpressure();
    run_op(1'b0, 64'h7F, 64'h01, 1'b0, 1'b0, 5, "bp8");
    run_op(1'b1, 64'h8000, 64'h0001, 1'b0, 1'b1, 5, "bp16");
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    run_op(1'b0, 64'h33, 64'h11, 1'b0, 1'b0, 0, "pre_abort");
    sel16 = 1'b0;
    drive_in(1'b1, 64'h0F, 64'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_in(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({ir8, ov8, s8, co8, of8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_reset got ir=%b ov=%b sum=%h cout=%b ovf=%b expected 1 0 00 0 0",
               ir8, ov8, s8, co8, of8);
    end
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ov8 || !ir8) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_result got activity=1 expected=0");
    end
    run_op(1'b0, 64'h0F, 64'h01, 1'b0, 1'b0, 0, "after_abort");
  endtask

  task automatic test_reset_priority();
    sel16 = 1'b0;
    drive_in(1'b1, 64'h12, 64'h34, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_in(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    checks++;
    if ({ir8, ov8} !== 2'b10) begin
      errors++;
      $display("FAIL rst_vs_accept got ir=%b ov=%b expected ir=1 ov=0", ir8, ov8);
    end
    run_op(1'b0, 64'hA5, 64'h5A, 1'b1, 1'b0, 0, "after_prio");
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++)
      run_op(1'b0, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), "rand8");
    for (int i = 0; i < 1000; i++)
      run_op(1'b1, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 1)), "rand16");
  endtask

  initial begin
    sel16 = 1'b0;
    rst_n = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_reset_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
